draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 127, the maximum number of WAIT cycles allowed before a draw is abandoned (legal range 1..255).
REQ-002 SHALL have port iClock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iResetn, input, 1, reset: asynchronous assertion, active-low.
REQ-004 SHALL have port iReq, input, 4, per-requester draw request (level), bit n = requester n.
REQ-005 SHALL have port iXBus, input, 32, packed box X coordinates; requester n uses bits [8n+7:8n].
REQ-006 SHALL have port iYBus, input, 28, packed box Y coordinates; requester n uses bits [7n+6:7n].
REQ-007 SHALL have port iColourBus, input, 12, packed colours; requester n uses bits [3n+2:3n].
REQ-008 SHALL have port iDrawDone, input, 1, one-cycle done pulse from the box drawer.
REQ-009 SHALL have port oX, output, 8, latched X driven to the box drawer.
REQ-010 SHALL have port oY, output, 7, latched Y driven to the box drawer.
REQ-011 SHALL have port oColour, output, 3, latched colour driven to the box drawer.
REQ-012 SHALL have port oLoadX, output, 1, one-cycle start pulse to the box drawer.
REQ-013 SHALL have port oGrant, output, 4, one-hot grant to the requester being served; all zero when idle.
REQ-014 SHALL have port oAck, output, 4, one-cycle completion pulse to the served requester.
REQ-015 SHALL have port oBusy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port oTimeout, output, 1, one-cycle pulse when a draw is abandoned.

Function
REQ-017 SHALL implement states IDLE, LOAD, WAIT, ACK, and SHALL register all outputs.
REQ-018 IDLE: if iReq is nonzero, SHALL select the winner round-robin, searching from last+1 upward mod 4. On the same edge it SHALL latch the winner's X/Y/colour into oX/oY/oColour, set oGrant one-hot, and go to LOAD. If iReq is zero, SHALL stay in IDLE.
REQ-019 LOAD: SHALL hold oLoadX=1 for exactly one cycle, clear the watchdog counter to 0, and then go to WAIT.
REQ-020 WAIT: SHALL increment an 8-bit watchdog counter each cycle. On iDrawDone=1 it SHALL go to ACK. If the counter reaches TIMEOUT without done, it SHALL pulse oTimeout for one cycle and go to ACK.
REQ-021 If iDrawDone and timeout occur in the same WAIT cycle, done SHALL win and oTimeout SHALL stay 0.
REQ-022 ACK: SHALL pulse oAck[winner] for one cycle, clear oGrant, set last=winner, and return to IDLE.
REQ-023 Minimum service latency, from request seen in IDLE to oAck: 3 cycles plus the drawer's done latency.
REQ-024 oX/oY/oColour SHALL remain stable from LOAD entry until the next grant; changes on iXBus/iYBus/iColourBus during service SHALL be ignored.
REQ-025 iDrawDone SHALL be ignored outside WAIT.
REQ-026 Changes on iReq while not in IDLE SHALL be ignored; a requester dropping iReq mid-service SHALL still receive oAck.
REQ-027 A requester still asserting iReq after its oAck SHALL be eligible again, ranked lowest behind the others.
REQ-028 At most one oGrant bit and at most one oAck bit SHALL ever be high.

Reset
REQ-029 On iResetn=0, SHALL immediately enter IDLE with oX=0, oY=0, oColour=0, oLoadX=0, oGrant=0, oAck=0, oBusy=0, oTimeout=0, watchdog=0, last=3 (so requester 0 has first priority).
REQ-030 Reset asserted mid-service SHALL abandon the draw, with no oAck and no oTimeout issued.
REQ-031 After iResetn deasserts, the first arbitration SHALL occur on the next rising edge with iReq nonzero.

Verification
REQ-032 Single request: iReq=0001, X0=10, Y0=20, colour 5; done returned 40 cycles after oLoadX -> oX=10, oY=20, oColour=5, one oLoadX pulse, oAck=0001 two cycles after done.
REQ-033 Contention: iReq=1111 held continuously -> grant order 0,1,2,3,0, with exactly one oLoadX per grant.
REQ-034 Timeout: iReq=0100 and iDrawDone held 0 -> oTimeout pulses once TIMEOUT cycles after WAIT entry, followed by oAck=0100 and return to IDLE.
REQ-035 Done on the timeout cycle -> oTimeout stays 0 and oAck is issued.
REQ-036 Reset during WAIT -> all outputs 0 at once, no oAck; after release, iReq=1000 -> requester 3 is granted.
REQ-037 Spurious iDrawDone in IDLE or LOAD -> no state change and no oAck.

Source files
------------

// File: rtl/draw_arbiter.sv
// draw_arbiter: four-way round-robin arbiter in front of a single box drawer.
// One requester is served at a time: its X/Y/colour are latched, a one-cycle
// oLoadX starts the drawer, and the arbiter waits for iDrawDone (or a
// watchdog timeout) before acknowledging the requester and returning to idle.
//
// Ports:
//   iClock      - clock, rising edge
//   iResetn     - asynchronous active-low reset
//   iReq        - per-requester request level (bit n = requester n)
//   iXBus       - packed X coordinates, 8 bits per requester
//   iYBus       - packed Y coordinates, 7 bits per requester
//   iColourBus  - packed colours, 3 bits per requester
//   iDrawDone   - one-cycle done pulse from the drawer (sampled in WAIT only)
//   oX/oY/oColour - latched coordinates/colour of the served requester
//   oLoadX      - one-cycle drawer start pulse
//   oGrant      - one-hot grant of the requester being served
//   oAck        - one-cycle completion pulse to the served requester
//   oBusy       - high whenever not idle
//   oTimeout    - one-cycle pulse when a draw is abandoned by the watchdog
module draw_arbiter #(
    parameter int unsigned TIMEOUT = 127
) (
    input  logic        iClock,
    input  logic        iResetn,
    input  logic [3:0]  iReq,
    input  logic [31:0] iXBus,
    input  logic [27:0] iYBus,
    input  logic [11:0] iColourBus,
    input  logic        iDrawDone,
    output logic [7:0]  oX,
    output logic [6:0]  oY,
    output logic [2:0]  oColour,
    output logic        oLoadX,
    output logic [3:0]  oGrant,
    output logic [3:0]  oAck,
    output logic        oBusy,
    output logic        oTimeout
);

    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        load_q, load_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  wd_q, wd_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  winner_q, winner_d;

    // Per-requester views of the packed buses.
    logic [7:0]  x_arr      [4];
    logic [6:0]  y_arr      [4];
    logic [2:0]  colour_arr [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign x_arr[g]      = iXBus[8*g +: 8];
        assign y_arr[g]      = iYBus[7*g +: 7];
        assign colour_arr[g] = iColourBus[3*g +: 3];
    end

    // Round-robin pick: scan last+1, last+2, ... (mod 4); first requester wins.
    logic        found;
    logic [1:0]  pick;

    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && iReq[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        load_d    = 1'b0;
        grant_d   = grant_q;
        ack_d     = '0;
        timeout_d = 1'b0;
        wd_d      = wd_q;
        last_d    = last_q;
        winner_d  = winner_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    winner_d = pick;
                    grant_d  = 4'b0001 << pick;
                    x_d      = x_arr[pick];
                    y_d      = y_arr[pick];
                    colour_d = colour_arr[pick];
                    load_d   = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 8'd1;
                // Done takes priority over a timeout landing on the same cycle.
                if (iDrawDone) begin
                    state_d = S_ACK;
                end else if (wd_q + 8'd1 == TIMEOUT_8) begin
                    timeout_d = 1'b1;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                ack_d   = grant_q;
                grant_d = '0;
                last_d  = winner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            load_q    <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            last_q    <= 2'd3;
            winner_q  <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            load_q    <= load_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
        end
    end

    assign oX       = x_q;
    assign oY       = y_q;
    assign oColour  = colour_q;
    assign oLoadX   = load_q;
    assign oGrant   = grant_q;
    assign oAck     = ack_q;
    assign oBusy    = busy_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: directed scenarios plus randomized transactions,
// checked against a transaction-level reference model (round-robin pointer,
// expected latencies) kept in the bench.
module tb_draw_arbiter;

    localparam int TO = 127;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] xbus;
    logic [27:0] ybus;
    logic [11:0] cbus;
    logic        done;
    logic [7:0]  o_x;
    logic [6:0]  o_y;
    logic [2:0]  o_c;
    logic        o_load;
    logic [3:0]  o_grant;
    logic [3:0]  o_ack;
    logic        o_busy;
    logic        o_to;

    int n_cmp = 0;
    int n_err = 0;
    int m_last = 3;  // model: last served requester

    draw_arbiter #(.TIMEOUT(TO)) dut (
        .iClock     (clk),
        .iResetn    (rst_n),
        .iReq       (req),
        .iXBus      (xbus),
        .iYBus      (ybus),
        .iColourBus (cbus),
        .iDrawDone  (done),
        .oX         (o_x),
        .oY         (o_y),
        .oColour    (o_c),
        .oLoadX     (o_load),
        .oGrant     (o_grant),
        .oAck       (o_ack),
        .oBusy      (o_busy),
        .oTimeout   (o_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requesting index from last+1 upward, mod 4.
    function automatic int model_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_load"},  32'(o_load),  32'd0);
        chk({tag, "_to"},    32'(o_to),    32'd0);
    endtask

    // One full service. dlat = WAIT cycle on which done is presented
    // (0 or > TO means never). Request pattern may be scrambled mid-service.
    task automatic txn(input logic [3:0] r, input int dlat, input bit keep,
                       input logic [31:0] xb, input logic [27:0] yb, input logic [11:0] cb);
        int w;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        bit exp_to;
        int k;
        w  = model_pick(r, m_last);
        ex = 8'(xb >> (8 * w));
        ey = 7'(yb >> (7 * w));
        ec = 3'(cb >> (3 * w));
        req = r; xbus = xb; ybus = yb; cbus = cb; done = 1'b0;
        tick();  // arbitration edge
        chk("grant",  32'(o_grant), 32'(4'b0001 << w));
        chk("load1",  32'(o_load),  32'd1);
        chk("busy",   32'(o_busy),  32'd1);
        chk("ack0",   32'(o_ack),   32'd0);
        chk("x",      32'(o_x),     32'(ex));
        chk("y",      32'(o_y),     32'(ey));
        chk("colour", 32'(o_c),     32'(ec));
        // Bus churn, request churn and a spurious done in LOAD: all ignored.
        xbus = $urandom; ybus = 28'($urandom); cbus = 12'($urandom);
        if (!keep) req = 4'($urandom);
        done = 1'b1;
        tick();  // LOAD -> WAIT
        done = 1'b0;
        chk("load_once", 32'(o_load), 32'd0);
        chk("grant_hold", 32'(o_grant), 32'(4'b0001 << w));
        exp_to = 1'b0;
        k = 1;
        while (1) begin
            done = (k == dlat);
            tick();
            if (k == dlat) break;
            if (k == TO) begin exp_to = 1'b1; break; end
            chk("wait_ack0", 32'(o_ack), 32'd0);
            chk("wait_to0",  32'(o_to),  32'd0);
            chk("wait_busy", 32'(o_busy), 32'd1);
            k++;
        end
        done = 1'b0;
        chk("timeout", 32'(o_to),   32'(exp_to));
        chk("ack_wait", 32'(o_ack), 32'd0);
        chk("ack_busy", 32'(o_busy), 32'd1);
        tick();
        chk("ack",        32'(o_ack),   32'(4'b0001 << w));
        chk("post_grant", 32'(o_grant), 32'd0);
        chk("post_busy",  32'(o_busy),  32'd0);
        chk("post_to",    32'(o_to),    32'd0);
        chk("stable_x",   32'({o_x, o_y, o_c}), 32'({ex, ey, ec}));
        m_last = w;
        req = keep ? r : 4'd0;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; xbus = '0; ybus = '0; cbus = '0; done = 1'b0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_xyz", 32'({o_x, o_y, o_c}), 32'd0);
        rst_n = 1'b1;

        // Idle with no request, plus spurious done in IDLE.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_idle("idle_done");
        chk("idle_done_ack", 32'(o_ack), 32'd0);

        // Single request, done 40 WAIT cycles in.
        txn(4'b0001, 40, 1'b0, {24'h0, 8'd10}, {21'h0, 7'd20}, {9'h0, 3'd5});
        tick();
        chk("ack_pulse_once", 32'(o_ack), 32'd0);

        // Contention: all requesting continuously -> 1,2,3,0,1 after the above.
        for (int i = 0; i < 5; i++)
            txn(4'b1111, 1 + i, 1'b1, $urandom, 28'($urandom), 12'($urandom));
        req = '0;
        tick();

        // Timeout and done-on-timeout-cycle boundary.
        txn(4'b0100, 0, 1'b0, $urandom, 28'($urandom), 12'($urandom));
        txn(4'b0100, TO, 1'b0, $urandom, 28'($urandom), 12'($urandom));
        txn(4'b0010, TO - 1, 1'b0, $urandom, 28'($urandom), 12'($urandom));

        // Reset during WAIT: outputs clear immediately, no ack afterwards.
        req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_xyz", 32'({o_x, o_y, o_c}), 32'd0);
        req = '0;
        tick();
        #2 rst_n = 1'b1;
        m_last = 3;
        tick();
        chk("rst_no_ack", 32'(o_ack), 32'd0);
        chk("rst_no_to",  32'(o_to),  32'd0);
        txn(4'b1000, 3, 1'b0, $urandom, 28'($urandom), 12'($urandom));

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            logic [3:0] r;
            int dl;
            r  = 4'($urandom_range(1, 15));
            dl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 50));
            txn(r, dl, 1'($urandom), $urandom, 28'($urandom), 12'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                req = '0;
                tick();
                chk_idle("rand_gap");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
